// File: rtl/cond_flag_unit_pkg.sv
// cond_flag_unit_pkg: LEGv8 condition-code encodings and NZCV bit positions
package cond_flag_unit_pkg;
  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_e;
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;
endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: ALU status, B.cond request and branch-decision signals
interface cond_flag_unit_if;
  logic       flag_we;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_overflow;
  logic       cond_valid;
  logic [3:0] cond_code;
  logic       stall;
  logic       flush;
  logic [3:0] nzcv;
  logic       br_valid;
  logic       br_taken;
  modport master (
    output flag_we, alu_negative, alu_zero, alu_carry, alu_overflow,
           cond_valid, cond_code, stall, flush,
    input  nzcv, br_valid, br_taken
  );
  modport slave (
    input  flag_we, alu_negative, alu_zero, alu_carry, alu_overflow,
           cond_valid, cond_code, stall, flush,
    output nzcv, br_valid, br_taken
  );
endinterface

// File: rtl/cond_flag_unit_cond_eval.sv
// cond_eval: combinational LEGv8 B.cond evaluation of cond_code against NZCV
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond_code,
  input  logic [3:0] nzcv,
  output logic       taken
);
  logic       n, z, c, v;
  logic [7:0] base;
  assign n = nzcv[NZCV_N];
  assign z = nzcv[NZCV_Z];
  assign c = nzcv[NZCV_C];
  assign v = nzcv[NZCV_V];
  // Even codes test a base condition, odd codes invert it; 111x is always true.
  assign base  = {1'b1, !z && (n == v), n == v, c && !z, v, n, c, z};
  assign taken = base[cond_code[3:1]] ^ (cond_code[0] && cond_code[3:1] != 3'd7);
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register and registered B.cond branch decision.
// Define FLAG_BYPASS_EN to evaluate against same-cycle ALU flags on flag_we.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter logic [3:0] RST_NZCV = 4'b0000
) (
  input logic             clk,
  input logic             rst,
  cond_flag_unit_if.slave bus
);
  logic [3:0] nzcv_q, nzcv_d, alu_flags, f;
  logic       br_valid_q, br_valid_d, br_taken_q, br_taken_d, taken;
  assign alu_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
`ifdef FLAG_BYPASS_EN
  assign f = bus.flag_we ? alu_flags : nzcv_q;
`else
  assign f = nzcv_q;
`endif
  cond_eval u_eval (
    .cond_code(bus.cond_code),
    .nzcv     (f),
    .taken    (taken)
  );
  always_comb begin
    nzcv_d     = (bus.flag_we && !bus.stall && !bus.flush) ? alu_flags : nzcv_q;
    br_valid_d = bus.flush ? 1'b0 : bus.stall ? br_valid_q : bus.cond_valid;
    br_taken_d = bus.flush ? 1'b0 : bus.stall ? br_taken_q : bus.cond_valid && taken;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      nzcv_q     <= RST_NZCV;
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else begin
      nzcv_q     <= nzcv_d;
      br_valid_q <= br_valid_d;
      br_taken_q <= br_taken_d;
    end
  end
  assign bus.nzcv     = nzcv_q;
  assign bus.br_valid = br_valid_q;
  assign bus.br_taken = br_taken_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
// tb_cond_flag_unit: scoreboard-driven checks of flag capture and B.cond results
module tb_cond_flag_unit;
  import cond_flag_unit_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sb[$];
  bit   exp_t;
  cond_flag_unit_if bus ();
  cond_flag_unit #(.RST_NZCV(4'b0000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
`ifdef FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  function automatic bit ref_eval(input logic [3:0] code, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (code)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.flag_we = 0; bus.cond_valid = 0; bus.stall = 0; bus.flush = 0;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = 4'b0000;
    bus.cond_code = 4'h0;
  endtask
  task automatic load_flags(input logic [3:0] f);
    bus.flag_we = 1;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = f;
    tick();
    bus.flag_we = 0;
  endtask
  task automatic test_reset();
    idle();
    rst = 1; tick(); rst = 0; tick();
    vectors++;
    if (bus.nzcv !== 4'b0000 || bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: nzcv=%b v=%b t=%b want 0000 0 0", bus.nzcv, bus.br_valid, bus.br_taken);
    end
    bus.cond_valid = 1; bus.cond_code = COND_EQ; sb.push_back(1'b0);
    tick(); bus.cond_valid = 0;
    exp_t = sb.pop_front();
    vectors++;
    if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t) begin
      miscompares++;
      $display("FAIL reset_eq: v=%b t=%b want 1 %b", bus.br_valid, bus.br_taken, exp_t);
    end
  endtask
  task automatic test_signed();
    logic [3:0] codes [3] = '{COND_GE, COND_LT, COND_GT};
    bit         want  [3] = '{1'b1, 1'b0, 1'b1};
    load_flags(4'b1001);
    vectors++;
    if (bus.nzcv !== 4'b1001) begin
      miscompares++;
      $display("FAIL nzcv_1001: nzcv=%b want 1001", bus.nzcv);
    end
    for (int i = 0; i < 3; i++) begin
      bus.cond_valid = 1; bus.cond_code = codes[i]; sb.push_back(want[i]);
      tick();
      exp_t = sb.pop_front();
      vectors++;
      if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t) begin
        miscompares++;
        $display("FAIL signed code=%h: v=%b t=%b want 1 %b", codes[i], bus.br_valid, bus.br_taken, exp_t);
      end
    end
    bus.cond_valid = 0;
  endtask
  task automatic test_sweep();
    logic [3:0] codes [4] = '{COND_HI, COND_LS, COND_HS, COND_NE};
    bit         want  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    load_flags(4'b0110);
    for (int i = 0; i < 4; i++) begin
      bus.cond_valid = 1; bus.cond_code = codes[i]; sb.push_back(want[i]);
      tick();
      exp_t = sb.pop_front();
      vectors++;
      if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t) begin
        miscompares++;
        $display("FAIL unsigned code=%h: v=%b t=%b want 1 %b", codes[i], bus.br_valid, bus.br_taken, exp_t);
      end
    end
    for (int k = 0; k < 3; k++) begin
      logic [3:0] fl = (k == 0) ? 4'b0110 : (k == 1) ? 4'b1001 : 4'b0010;
      if (k != 0) load_flags(fl);
      for (int i = 0; i < 16; i++) begin
        bus.cond_valid = 1; bus.cond_code = 4'(i); sb.push_back(ref_eval(4'(i), fl));
        tick();
        exp_t = sb.pop_front();
        vectors++;
        if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t) begin
          miscompares++;
          $display("FAIL sweep f=%b code=%h: v=%b t=%b want 1 %b", fl, i, bus.br_valid, bus.br_taken, exp_t);
        end
      end
    end
    bus.cond_valid = 0; tick();
    vectors++;
    if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_sweep: v=%b t=%b want 0 0", bus.br_valid, bus.br_taken);
    end
  endtask
  task automatic test_bypass();
    idle(); rst = 1; tick(); rst = 0;
    bus.flag_we = 1; bus.alu_zero = 1; bus.cond_valid = 1; bus.cond_code = COND_EQ;
    sb.push_back(BYPASS);
    tick(); idle();
    exp_t = sb.pop_front();
    vectors++;
    if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t || bus.nzcv !== 4'b0100) begin
      miscompares++;
      $display("FAIL bypass: v=%b t=%b nzcv=%b want 1 %b 0100", bus.br_valid, bus.br_taken, bus.nzcv, exp_t);
    end
  endtask
  task automatic test_stall();
    bus.cond_valid = 1; bus.cond_code = COND_AL; tick();
    bus.stall = 1; bus.flag_we = 1; bus.cond_code = COND_NE;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.br_valid !== 1'b1 || bus.br_taken !== 1'b1 || bus.nzcv !== 4'b0100) begin
        miscompares++;
        $display("FAIL stall_hold %0d: v=%b t=%b nzcv=%b want 1 1 0100", i, bus.br_valid, bus.br_taken, bus.nzcv);
      end
    end
    bus.stall = 0; bus.flag_we = 0; sb.push_back(ref_eval(COND_NE, 4'b0100));
    tick(); bus.cond_valid = 0;
    exp_t = sb.pop_front();
    vectors++;
    if (bus.br_valid !== 1'b1 || bus.br_taken !== exp_t || bus.nzcv !== 4'b0100) begin
      miscompares++;
      $display("FAIL stall_release: v=%b t=%b nzcv=%b want 1 %b 0100", bus.br_valid, bus.br_taken, bus.nzcv, exp_t);
    end
  endtask
  task automatic test_flush_reset();
    bus.cond_valid = 1; bus.cond_code = COND_AL; bus.flag_we = 1; bus.flush = 1;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = 4'b1011;
    tick();
    vectors++;
    if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0 || bus.nzcv !== 4'b0100) begin
      miscompares++;
      $display("FAIL flush: v=%b t=%b nzcv=%b want 0 0 0100", bus.br_valid, bus.br_taken, bus.nzcv);
    end
    bus.flush = 0; bus.flag_we = 0; tick();
    bus.flag_we = 1; rst = 1; tick(); rst = 0; idle();
    vectors++;
    if (bus.br_valid !== 1'b0 || bus.br_taken !== 1'b0 || bus.nzcv !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset: v=%b t=%b nzcv=%b want 0 0 0000", bus.br_valid, bus.br_taken, bus.nzcv);
    end
  endtask
  task automatic test_back_to_back();
    logic [3:0] model = 4'b0000;
    bit         want_v;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] fl = 4'($urandom_range(0, 15));
      bus.flag_we = 1'($urandom_range(0, 1));
      bus.cond_valid = ($urandom_range(0, 3) != 0);
      bus.cond_code = 4'($urandom_range(0, 15));
      {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = fl;
      want_v = bus.cond_valid;
      if (bus.cond_valid) sb.push_back(ref_eval(bus.cond_code, (BYPASS && bus.flag_we) ? fl : model));
      if (bus.flag_we) model = fl;
      tick();
      exp_t = want_v ? sb.pop_front() : 1'b0;
      vectors++;
      if (bus.br_valid !== want_v || bus.br_taken !== exp_t || bus.nzcv !== model) begin
        miscompares++;
        $display("FAIL b2b %0d: v=%b t=%b nzcv=%b want %b %b %b", i, bus.br_valid, bus.br_taken, bus.nzcv, want_v, exp_t, model);
      end
    end
    idle();
  endtask
  initial begin
    rst = 1;
    idle();
    test_reset();
    test_signed();
    test_sweep();
    test_bypass();
    test_stall();
    test_flush_reset();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
